pipe_controller: RTL
====================

PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 Parameter ALUCTRL_W, default 3, is the ALU control width; legal values are 3 and 4.
REQ-002 Parameter EXT_ISA, default 1; when 1, addi/andi/ori/slti/bne are decoded, and when 0 they are illegal.
REQ-003 clk  input  1  sole clock; all state is updated on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 op_d, funct_d  input  6 each  instruction fields in the ID stage.
REQ-006 stall_e, flush_e  input  1 each  hazard-unit controls for the ID->EX register.
REQ-007 branch_d, bne_d, jump_d, zeroext_d, illegal_d  output  1 each  combinational ID-stage decode.
REQ-008 regdst_e, alusrc_e, regwrite_e, memtoreg_e, memwrite_e  output  1 each  registered EX-stage controls.
REQ-009 alucontrol_e  output  ALUCTRL_W  registered EX-stage ALU operation.
REQ-010 regwrite_m, memtoreg_m, memwrite_m  output  1 each  registered MEM-stage controls.
REQ-011 regwrite_w, memtoreg_w  output  1 each  registered WB-stage controls.

Function
REQ-012 ID decode SHALL be purely combinational from op_d/funct_d, with zero cycles of latency.
REQ-013 Decode table:
- R-type (op 0x00): regdst, regwrite.
- lw (0x23): alusrc, regwrite, memtoreg.
- sw (0x2B): alusrc, memwrite.
- beq (0x04): branch, ALU sub.
- j (0x02): jump.
- EXT_ISA only:
  - addi (0x08): alusrc, regwrite, ALU add.
  - andi (0x0C) and ori (0x0D): alusrc, regwrite, zeroext, ALU and/or respectively.
  - slti (0x0A): alusrc, regwrite, ALU slt.
  - bne (0x05): branch, bne, ALU sub.
REQ-014 ALU codes SHALL be add=010, sub=110, and=000, or=001, slt=111, zero-extended to ALUCTRL_W.
REQ-015 R-type funct mapping: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
REQ-016 When ALUCTRL_W=4, funct 0x27 SHALL map to nor=1100 and funct 0x26 SHALL map to xor=1101.
REQ-017 An unlisted op, or an unlisted funct with op 0x00, SHALL assert illegal_d and force all other decode outputs to 0.
REQ-018 EX register update: when flush_e=1 the EX register SHALL load all-zero; otherwise, when stall_e=1, it SHALL hold; otherwise it SHALL load the ID decode.
REQ-019 flush_e SHALL take priority over stall_e when both are asserted.
REQ-020 While stall_e=1 and flush_e=0, the MEM register SHALL load a bubble (all zero) so that the held EX instruction is not duplicated.
REQ-021 The MEM and WB registers SHALL advance every cycle, and the WB register SHALL load the MEM register.
REQ-022 An instruction decoded in cycle N with no stall or flush SHALL appear at EX in N+1, MEM in N+2 and WB in N+3.
REQ-023 illegal_d SHALL NOT be pipelined, and an illegal instruction SHALL enter EX as a bubble.

Reset
REQ-024 rst_n=0 SHALL asynchronously clear every EX, MEM and WB output to 0, including alucontrol_e.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight controls, and the first edge after release SHALL load the ID decode normally.
REQ-026 ID-stage outputs are combinational and SHALL be unaffected by reset.

Structure
REQ-027 Opcode, funct and ALU-code constants SHALL reside in a shared package, ctrl_pkg, shared with the datapath.
REQ-028 Combinational decode SHALL be one sub-module, ctrl_decode (op+funct -> control bundle plus illegal flag), and the pipeline registers SHALL live in pipe_controller.

Verification
REQ-029 add (op 0x00, funct 0x20) at cycle N -> alucontrol_e=010 and regwrite_e=1 at N+1; regwrite_w=1 and memtoreg_w=0 at N+3.
REQ-030 lw (0x23) -> alusrc_e=1 at N+1; memtoreg_m=1 at N+2; regwrite_w=1 and memtoreg_w=1 at N+3.
REQ-031 sw (0x2B) with flush_e=1 at the capture edge -> memwrite_e=0 at N+1 and memwrite_m=0 at N+2.
REQ-032 andi (0x0C) with stall_e=1 for 2 cycles -> zeroext_d=1; EX holds alucontrol_e=000 and alusrc_e=1 for 3 cycles; MEM receives 2 bubbles, then the andi.
REQ-033 Illegal inputs:
- op 0x3F -> illegal_d=1 and a bubble in EX.
- EXT_ISA=0 with bne (0x05) -> illegal_d=1.
- ALUCTRL_W=4 with funct 0x27 -> alucontrol_e=1100.
REQ-034 rst_n pulsed low between clock edges while lw is in MEM -> all registered outputs are 0 immediately; the next decode flows normally.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control constants for the pipelined datapath: opcodes, funct codes, ALU codes and
// the per-stage control bundles carried by the pipeline registers.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_BNE   = 6'h05;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_XOR = 6'h26;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // Four-bit canonical codes; narrower ALUs take the low bits.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    typedef struct packed {
        logic regdst;
        logic alusrc;
        logic regwrite;
        logic memtoreg;
        logic memwrite;
        logic branch;
        logic bne;
        logic jump;
        logic zeroext;
    } ctrl_t;

    typedef struct packed {
        logic regdst;
        logic alusrc;
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } ex_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } mem_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    function automatic ex_ctrl_t to_ex(input ctrl_t c);
        ex_ctrl_t r;
        r.regdst   = c.regdst;
        r.alusrc   = c.alusrc;
        r.regwrite = c.regwrite;
        r.memtoreg = c.memtoreg;
        r.memwrite = c.memwrite;
        return r;
    endfunction

    function automatic mem_ctrl_t to_mem(input ex_ctrl_t c);
        mem_ctrl_t r;
        r.regwrite = c.regwrite;
        r.memtoreg = c.memtoreg;
        r.memwrite = c.memwrite;
        return r;
    endfunction

    function automatic wb_ctrl_t to_wb(input mem_ctrl_t c);
        wb_ctrl_t r;
        r.regwrite = c.regwrite;
        r.memtoreg = c.memtoreg;
        return r;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ID-stage main/ALU decoder: op + funct -> control bundle, ALU code and illegal flag.
// Illegal encodings drive every control and the ALU code to zero.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3,
    parameter int unsigned EXT_ISA   = 1
) (
    input  logic [5:0]           op_i,
    input  logic [5:0]           funct_i,
    output ctrl_t                ctrl_o,
    output logic [ALUCTRL_W-1:0] alu_o,
    output logic                 illegal_o
);

    localparam bit ExtEn  = (EXT_ISA != 0);
    localparam bit WideEn = (ALUCTRL_W == 4);

    always_comb begin
        ctrl_o    = '0;
        alu_o     = '0;
        illegal_o = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                ctrl_o.regdst   = 1'b1;
                ctrl_o.regwrite = 1'b1;
                case (funct_i)
                    FUNCT_ADD: alu_o = ALUCTRL_W'(ALU_ADD);
                    FUNCT_SUB: alu_o = ALUCTRL_W'(ALU_SUB);
                    FUNCT_AND: alu_o = ALUCTRL_W'(ALU_AND);
                    FUNCT_OR:  alu_o = ALUCTRL_W'(ALU_OR);
                    FUNCT_SLT: alu_o = ALUCTRL_W'(ALU_SLT);
                    FUNCT_NOR: begin
                        if (WideEn) alu_o = ALUCTRL_W'(ALU_NOR);
                        else        illegal_o = 1'b1;
                    end
                    FUNCT_XOR: begin
                        if (WideEn) alu_o = ALUCTRL_W'(ALU_XOR);
                        else        illegal_o = 1'b1;
                    end
                    default:   illegal_o = 1'b1;
                endcase
            end
            OP_LW: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memtoreg = 1'b1;
                alu_o           = ALUCTRL_W'(ALU_ADD);
            end
            OP_SW: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.memwrite = 1'b1;
                alu_o           = ALUCTRL_W'(ALU_ADD);
            end
            OP_BEQ: begin
                ctrl_o.branch = 1'b1;
                alu_o         = ALUCTRL_W'(ALU_SUB);
            end
            OP_J: ctrl_o.jump = 1'b1;
            OP_ADDI: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.regwrite = 1'b1;
                alu_o           = ALUCTRL_W'(ALU_ADD);
                illegal_o       = !ExtEn;
            end
            OP_ANDI: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.zeroext  = 1'b1;
                alu_o           = ALUCTRL_W'(ALU_AND);
                illegal_o       = !ExtEn;
            end
            OP_ORI: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.zeroext  = 1'b1;
                alu_o           = ALUCTRL_W'(ALU_OR);
                illegal_o       = !ExtEn;
            end
            OP_SLTI: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.regwrite = 1'b1;
                alu_o           = ALUCTRL_W'(ALU_SLT);
                illegal_o       = !ExtEn;
            end
            OP_BNE: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.bne    = 1'b1;
                alu_o         = ALUCTRL_W'(ALU_SUB);
                illegal_o     = !ExtEn;
            end
            default: illegal_o = 1'b1;
        endcase
        if (illegal_o) begin
            ctrl_o = '0;
            alu_o  = '0;
        end
    end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined control unit: combinational ID decode feeding ID->EX, EX->MEM and MEM->WB
// control registers with hazard-unit stall/flush on the EX register.
module pipe_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3,
    parameter int unsigned EXT_ISA   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           op_d,
    input  logic [5:0]           funct_d,
    input  logic                 stall_e,
    input  logic                 flush_e,
    output logic                 branch_d,
    output logic                 bne_d,
    output logic                 jump_d,
    output logic                 zeroext_d,
    output logic                 illegal_d,
    output logic                 regdst_e,
    output logic                 alusrc_e,
    output logic                 regwrite_e,
    output logic                 memtoreg_e,
    output logic                 memwrite_e,
    output logic [ALUCTRL_W-1:0] alucontrol_e,
    output logic                 regwrite_m,
    output logic                 memtoreg_m,
    output logic                 memwrite_m,
    output logic                 regwrite_w,
    output logic                 memtoreg_w
);

    ctrl_t                dec_ctrl;
    logic [ALUCTRL_W-1:0] dec_alu;

    ex_ctrl_t             ex_d, ex_q;
    logic [ALUCTRL_W-1:0] alu_e_d, alu_e_q;
    mem_ctrl_t            mem_d, mem_q;
    wb_ctrl_t             wb_d, wb_q;

    ctrl_decode #(
        .ALUCTRL_W (ALUCTRL_W),
        .EXT_ISA   (EXT_ISA)
    ) u_decode (
        .op_i      (op_d),
        .funct_i   (funct_d),
        .ctrl_o    (dec_ctrl),
        .alu_o     (dec_alu),
        .illegal_o (illegal_d)
    );

    always_comb begin
        ex_d    = ex_q;
        alu_e_d = alu_e_q;
        if (flush_e) begin
            ex_d    = '0;
            alu_e_d = '0;
        end else if (!stall_e) begin
            ex_d    = to_ex(dec_ctrl);
            alu_e_d = dec_alu;
        end
        // A held EX instruction must reach MEM only once, so MEM takes a bubble meanwhile.
        mem_d = (stall_e && !flush_e) ? '0 : to_mem(ex_q);
        wb_d  = to_wb(mem_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            alu_e_q <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
        end else begin
            ex_q    <= ex_d;
            alu_e_q <= alu_e_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
        end
    end

    assign branch_d     = dec_ctrl.branch;
    assign bne_d        = dec_ctrl.bne;
    assign jump_d       = dec_ctrl.jump;
    assign zeroext_d    = dec_ctrl.zeroext;

    assign regdst_e     = ex_q.regdst;
    assign alusrc_e     = ex_q.alusrc;
    assign regwrite_e   = ex_q.regwrite;
    assign memtoreg_e   = ex_q.memtoreg;
    assign memwrite_e   = ex_q.memwrite;
    assign alucontrol_e = alu_e_q;

    assign regwrite_m   = mem_q.regwrite;
    assign memtoreg_m   = mem_q.memtoreg;
    assign memwrite_m   = mem_q.memwrite;

    assign regwrite_w   = wb_q.regwrite;
    assign memtoreg_w   = wb_q.memtoreg;

endmodule
